mem_bus_ctrl: RTL and testbench

Shared memory controller directly downstream of the two snooping `cache` instances. It accepts one RD/WT request at a time from either cache's memory port, arbitrates round-robin, serves the request from an internal word-addressed memory after a fixed latency, and returns a one-cycle `readEn`/`writeDone` completion pulse. It is the only path to backing store; coherence stays entirely in the caches.

---
 rtl/mem_bus_ctrl_pkg.sv | 30 +++
 rtl/mem_bus_ctrl_if.sv | 46 ++++
 rtl/mem_bus_ctrl_mem_array.sv | 29 ++
 rtl/mem_bus_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller and the snooping caches:
// bus widths, request codes and controller state encodings.
package mem_bus_ctrl_pkg;

  localparam int unsigned ADDRWIDTH    = 16;
  localparam int unsigned WORDWIDTH    = 16;
  localparam int unsigned IOSTATEWIDTH = 2;

  // Request codes driven by a cache on its memory port; code 3 is illegal.
  localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd0;
  localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd1;
  localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd2;
  localparam logic [IOSTATEWIDTH-1:0] ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  // A port is requesting only for RD or WT.
  function automatic logic is_req(input logic [IOSTATEWIDTH-1:0] code);
    return (code == RD) || (code == WT);
  endfunction

  function automatic logic is_illegal(input logic [IOSTATEWIDTH-1:0] code);
    return (code == ILL);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Bundle of the two cache memory ports plus controller status.
// slave: the controller side; master: the cache (or bench) side.
interface mem_bus_ctrl_if;
  import mem_bus_ctrl_pkg::*;

  logic [IOSTATEWIDTH-1:0] rwFromCache0;
  logic [IOSTATEWIDTH-1:0] rwFromCache1;
  logic [ADDRWIDTH-1:0]    addrFromCache0;
  logic [ADDRWIDTH-1:0]    addrFromCache1;
  logic [WORDWIDTH-1:0]    dataFromCache0;
  logic [WORDWIDTH-1:0]    dataFromCache1;

  logic                    readEnToCache0;
  logic                    readEnToCache1;
  logic                    writeDoneToCache0;
  logic                    writeDoneToCache1;
  logic [ADDRWIDTH-1:0]    addrToCache0;
  logic [ADDRWIDTH-1:0]    addrToCache1;
  logic [WORDWIDTH-1:0]    dataToCache0;
  logic [WORDWIDTH-1:0]    dataToCache1;
  logic                    busy;
  logic                    errFlag;

  modport slave (
    input  rwFromCache0, rwFromCache1,
    input  addrFromCache0, addrFromCache1,
    input  dataFromCache0, dataFromCache1,
    output readEnToCache0, readEnToCache1,
    output writeDoneToCache0, writeDoneToCache1,
    output addrToCache0, addrToCache1,
    output dataToCache0, dataToCache1,
    output busy, errFlag
  );

  modport master (
    output rwFromCache0, rwFromCache1,
    output addrFromCache0, addrFromCache1,
    output dataFromCache0, dataFromCache1,
    input  readEnToCache0, readEnToCache1,
    input  writeDoneToCache0, writeDoneToCache1,
    input  addrToCache0, addrToCache1,
    input  dataToCache0, dataToCache1,
    input  busy, errFlag
  );

endinterface

// File: rtl/mem_bus_ctrl_mem_array.sv
// Single-port word RAM backing the controller. Writes commit on the clock
// edge; the read word is presented on rdata_o and captured by the caller's
// register on the same edge, so there is exactly one access per edge.
// Contents are deliberately not reset.
module mem_array #(
  parameter int unsigned MEM_AW    = 8,
  parameter int unsigned WORDWIDTH = mem_bus_ctrl_pkg::WORDWIDTH
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [MEM_AW-1:0]    addr_i,
  input  logic [WORDWIDTH-1:0] wdata_i,
  output logic [WORDWIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  logic [WORDWIDTH-1:0] mem_q [DEPTH];

  // Commit a write to the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Shared memory controller for two snooping caches. Accepts one RD/WT at a
// time, arbitrates round-robin, serves it from mem_array after LATENCY
// cycles and returns a one-cycle completion pulse to the granted port.
// The RESP state swallows the stale request a cache still drives for one
// cycle after seeing its pulse.
module mem_bus_ctrl import mem_bus_ctrl_pkg::*; #(
  parameter int unsigned MEM_AW  = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic           clk,
  input  logic           reset,
  mem_bus_ctrl_if.slave  bus
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  ctrl_state_e             state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    gnt_q, gnt_d;
  logic                    last_gnt_q, last_gnt_d;
  logic [IOSTATEWIDTH-1:0] rw_q, rw_d;
  logic [ADDRWIDTH-1:0]    addr_q, addr_d;
  logic [WORDWIDTH-1:0]    data_q, data_d;
  logic                    rd0_q, rd0_d, rd1_q, rd1_d;
  logic                    wd0_q, wd0_d, wd1_q, wd1_d;
  logic [ADDRWIDTH-1:0]    aout0_q, aout0_d, aout1_q, aout1_d;
  logic [WORDWIDTH-1:0]    dout0_q, dout0_d, dout1_q, dout1_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic                    req0_s, req1_s, sel_s, access_s, mem_we_s;
  logic [WORDWIDTH-1:0]    mem_rdata_s;

  assign req0_s   = is_req(bus.rwFromCache0);
  assign req1_s   = is_req(bus.rwFromCache1);
  // Access edge: last BUSY cycle. A reset on that edge aborts the write.
  assign access_s = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we_s = access_s && (rw_q == WT) && reset;

  mem_array #(
    .MEM_AW    (MEM_AW),
    .WORDWIDTH (WORDWIDTH)
  ) u_mem_array (
    .clk_i   (clk),
    .we_i    (mem_we_s),
    .addr_i  (addr_q[MEM_AW-1:0]),
    .wdata_i (data_q),
    .rdata_o (mem_rdata_s)
  );

  // Arbitration, FSM next state, counter and response register updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd0_d      = 1'b0;
    rd1_d      = 1'b0;
    wd0_d      = 1'b0;
    wd1_d      = 1'b0;
    aout0_d    = aout0_q;
    aout1_d    = aout1_q;
    dout0_d    = dout0_q;
    dout1_d    = dout1_q;
    err_d      = err_q;
    sel_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_illegal(bus.rwFromCache0) || is_illegal(bus.rwFromCache1)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        // On a tie the port that did not win last time is served.
        if (req0_s && req1_s) begin
          sel_s = ~last_gnt_q;
        end else if (req0_s) begin
          sel_s = 1'b0;
        end else begin
          sel_s = 1'b1;
        end
        if (req0_s || req1_s) begin
          gnt_d   = sel_s;
          rw_d    = sel_s ? bus.rwFromCache1   : bus.rwFromCache0;
          addr_d  = sel_s ? bus.addrFromCache1 : bus.addrFromCache0;
          data_d  = sel_s ? bus.dataFromCache1 : bus.dataFromCache0;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (rw_q == WT) begin
            if (gnt_q) begin
              wd1_d = 1'b1;
            end else begin
              wd0_d = 1'b1;
            end
          end else begin
            if (gnt_q) begin
              rd1_d   = 1'b1;
              aout1_d = addr_q;
              dout1_d = mem_rdata_s;
            end else begin
              rd0_d   = 1'b1;
              aout0_d = addr_q;
              dout0_d = mem_rdata_s;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_gnt_d = gnt_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      rw_q       <= IDEL;
      addr_q     <= '0;
      data_q     <= '0;
      rd0_q      <= 1'b0;
      rd1_q      <= 1'b0;
      wd0_q      <= 1'b0;
      wd1_q      <= 1'b0;
      aout0_q    <= '0;
      aout1_q    <= '0;
      dout0_q    <= '0;
      dout1_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
      wd0_q      <= wd0_d;
      wd1_q      <= wd1_d;
      aout0_q    <= aout0_d;
      aout1_q    <= aout1_d;
      dout0_q    <= dout0_d;
      dout1_q    <= dout1_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.readEnToCache0    = rd0_q;
  assign bus.readEnToCache1    = rd1_q;
  assign bus.writeDoneToCache0 = wd0_q;
  assign bus.writeDoneToCache1 = wd1_q;
  assign bus.addrToCache0      = aout0_q;
  assign bus.addrToCache1      = aout1_q;
  assign bus.dataToCache0      = dout0_q;
  assign bus.dataToCache1      = dout1_q;
  assign bus.busy              = busy_q;
  assign bus.errFlag           = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl (LATENCY=3, MEM_AW=8). Inputs change
// just after the rising edge, outputs are sampled on the falling edge.
// The reference keeps a word-array image of memory and per-port request
// queues and derives grant order and completion timing from the rules.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0]  rw;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic mdl_last;
  logic [15:0] mdl_mem [256];

  mem_bus_ctrl_if bus_if ();

  mem_bus_ctrl #(.MEM_AW(8), .LATENCY(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {readEn0, writeDone0, readEn1, writeDone1, busy, errFlag}
  function automatic logic [5:0] outs();
    return {bus_if.readEnToCache0, bus_if.writeDoneToCache0,
            bus_if.readEnToCache1, bus_if.writeDoneToCache1,
            bus_if.busy, bus_if.errFlag};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.rw   = ($urandom_range(0, 1) == 0) ? RD : WT;
    r.addr = {8'($urandom), 8'h20 + 8'($urandom_range(0, 7))};
    r.data = 16'($urandom);
    return r;
  endfunction

  task automatic drive0(input logic [1:0] rw, input logic [15:0] a, input logic [15:0] d);
    bus_if.rwFromCache0 = rw; bus_if.addrFromCache0 = a; bus_if.dataFromCache0 = d;
  endtask

  task automatic drive1(input logic [1:0] rw, input logic [15:0] a, input logic [15:0] d);
    bus_if.rwFromCache1 = rw; bus_if.addrFromCache1 = a; bus_if.dataFromCache1 = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus_if.rwFromCache0 = IDEL;
    bus_if.rwFromCache1 = IDEL;
    @(negedge clk);
    reset = 1'b1;
    mdl_last = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (outs() !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want %b", outs(), 6'b0);
    end
    n_cmp++;
    if ({bus_if.addrToCache0, bus_if.addrToCache1} !== 32'h0) begin
      n_err++; $display("FAIL reset_addr: got %h want 0", {bus_if.addrToCache0, bus_if.addrToCache1});
    end
    n_cmp++;
    if ({bus_if.dataToCache0, bus_if.dataToCache1} !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {bus_if.dataToCache0, bus_if.dataToCache1});
    end
  endtask

  task automatic test_write_read();
    logic [5:0] exp_v;
    @(negedge clk);
    drive0(WT, 16'h0012, 16'hBEEF);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = {1'b0, (k == 4), 1'b0, 1'b0, (k <= 4), 1'b0};
      n_cmp++;
      if (outs() !== exp_v) begin
        n_err++; $display("FAIL wt0_cycle%0d: got %b want %b", k, outs(), exp_v);
      end
      if (k == 4) begin
        @(posedge clk); #1; bus_if.rwFromCache0 = IDEL;
      end
    end
    mdl_mem[8'h12] = 16'hBEEF;
    drive1(RD, 16'h0012, 16'($urandom));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = {1'b0, 1'b0, (k == 4), 1'b0, (k <= 4), 1'b0};
      n_cmp++;
      if (outs() !== exp_v) begin
        n_err++; $display("FAIL rd1_cycle%0d: got %b want %b", k, outs(), exp_v);
      end
      if (k == 4) begin
        n_cmp++;
        if (bus_if.addrToCache1 !== 16'h0012 || bus_if.dataToCache1 !== mdl_mem[8'h12]) begin
          n_err++; $display("FAIL rd1_payload: got %h/%h want 0012/%h",
                            bus_if.addrToCache1, bus_if.dataToCache1, mdl_mem[8'h12]);
        end
        @(posedge clk); #1; bus_if.rwFromCache1 = IDEL;
      end
    end
    n_cmp++;
    if (bus_if.addrToCache1 !== 16'h0012 || bus_if.dataToCache1 !== 16'hBEEF) begin
      n_err++; $display("FAIL rd1_hold: got %h/%h want 0012/beef", bus_if.addrToCache1, bus_if.dataToCache1);
    end
    n_cmp++;
    if (bus_if.addrToCache0 !== 16'h0 || bus_if.dataToCache0 !== 16'h0) begin
      n_err++; $display("FAIL port0_quiet: got %h/%h want 0/0", bus_if.addrToCache0, bus_if.dataToCache0);
    end
  endtask

  // The cache keeps RD up through the edge that ends the pulse cycle.
  task automatic test_no_duplicate();
    logic [5:0] exp_v;
    @(negedge clk);
    drive0(RD, 16'h7733, 16'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_v = {(k == 4), 1'b0, 1'b0, 1'b0, (k <= 4), 1'b0};
      n_cmp++;
      if (outs() !== exp_v) begin
        n_err++; $display("FAIL hold_rd_cycle%0d: got %b want %b", k, outs(), exp_v);
      end
      if (k == 4) begin
        n_cmp++;
        if (bus_if.addrToCache0 !== 16'h7733 || bus_if.dataToCache0 !== mdl_mem[8'h33]) begin
          n_err++; $display("FAIL hold_rd_payload: got %h/%h want 7733/%h",
                            bus_if.addrToCache0, bus_if.dataToCache0, mdl_mem[8'h33]);
        end
        @(posedge clk); #1; bus_if.rwFromCache0 = IDEL;
      end
    end
  endtask

  task automatic test_round_robin();
    req_t q0[$];
    req_t q1[$];
    req_t h;
    int cyc, last_pulse, exp_port;
    logic [3:0] got_p, exp_p;
    logic [15:0] got_a, got_d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rand_req());
      q1.push_back(rand_req());
    end
    drive0(q0[0].rw, q0[0].addr, q0[0].data);
    drive1(q1[0].rw, q1[0].addr, q1[0].data);
    cyc = 0;
    last_pulse = 0;
    while ((q0.size() + q1.size() > 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      got_p = {bus_if.readEnToCache0, bus_if.writeDoneToCache0,
               bus_if.readEnToCache1, bus_if.writeDoneToCache1};
      if (got_p != 4'b0) begin
        if (q0.size() > 0 && q1.size() > 0) exp_port = mdl_last ? 0 : 1;
        else exp_port = (q0.size() > 0) ? 0 : 1;
        h = (exp_port == 0) ? q0[0] : q1[0];
        exp_p = (exp_port == 0) ? {(h.rw == RD), (h.rw == WT), 2'b00}
                                : {2'b00, (h.rw == RD), (h.rw == WT)};
        n_cmp++;
        if (got_p !== exp_p) begin
          n_err++; $display("FAIL rr_grant at cycle %0d: got %b want %b", cyc, got_p, exp_p);
        end
        n_cmp++;
        if ((cyc - last_pulse) != ((last_pulse == 0) ? 4 : 5)) begin
          n_err++; $display("FAIL rr_spacing: got %0d want %0d", cyc - last_pulse, (last_pulse == 0) ? 4 : 5);
        end
        if (h.rw == RD) begin
          got_a = (exp_port == 0) ? bus_if.addrToCache0 : bus_if.addrToCache1;
          got_d = (exp_port == 0) ? bus_if.dataToCache0 : bus_if.dataToCache1;
          n_cmp++;
          if (got_a !== h.addr || got_d !== mdl_mem[h.addr[7:0]]) begin
            n_err++; $display("FAIL rr_read port%0d: got %h/%h want %h/%h",
                              exp_port, got_a, got_d, h.addr, mdl_mem[h.addr[7:0]]);
          end
        end else begin
          mdl_mem[h.addr[7:0]] = h.data;
        end
        last_pulse = cyc;
        mdl_last = (exp_port == 1);
        @(posedge clk); #1;
        if (exp_port == 0) begin
          void'(q0.pop_front());
          if (q0.size() > 0) drive0(q0[0].rw, q0[0].addr, q0[0].data);
          else bus_if.rwFromCache0 = IDEL;
        end else begin
          void'(q1.pop_front());
          if (q1.size() > 0) drive1(q1[0].rw, q1[0].addr, q1[0].data);
          else bus_if.rwFromCache1 = IDEL;
        end
      end
    end
    n_cmp++;
    if (q0.size() + q1.size() != 0) begin
      n_err++; $display("FAIL rr_timeout: %0d requests still pending, want 0", q0.size() + q1.size());
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    drive0(WT, 16'h0001, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_if.rwFromCache0 = IDEL;
    @(negedge clk);
    reset = 1'b1;
    mdl_last = 1'b1;
    n_cmp++;
    if (outs() !== 6'b0) begin
      n_err++; $display("FAIL abort_state: got %b want %b", outs(), 6'b0);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== 6'b0) begin
        n_err++; $display("FAIL abort_quiet_cycle%0d: got %b want %b", k, outs(), 6'b0);
      end
    end
    drive0(RD, 16'h0001, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        n_cmp++;
        if (bus_if.readEnToCache0 !== 1'b1 || bus_if.dataToCache0 !== mdl_mem[8'h01]) begin
          n_err++; $display("FAIL abort_readback: got en=%b data=%h want en=1 data=%h",
                            bus_if.readEnToCache0, bus_if.dataToCache0, mdl_mem[8'h01]);
        end
        @(posedge clk); #1; bus_if.rwFromCache0 = IDEL;
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] exp_v;
    @(negedge clk);
    bus_if.rwFromCache1 = ILL;
    drive0(RD, 16'h0005, 16'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_v = {(k == 4), 1'b0, 1'b0, 1'b0, (k <= 4), 1'b1};
      n_cmp++;
      if (outs() !== exp_v) begin
        n_err++; $display("FAIL illegal_cycle%0d: got %b want %b", k, outs(), exp_v);
      end
      if (k == 4) begin
        n_cmp++;
        if (bus_if.addrToCache0 !== 16'h0005 || bus_if.dataToCache0 !== mdl_mem[8'h05]) begin
          n_err++; $display("FAIL illegal_payload: got %h/%h want 0005/%h",
                            bus_if.addrToCache0, bus_if.dataToCache0, mdl_mem[8'h05]);
        end
        @(posedge clk); #1; bus_if.rwFromCache0 = IDEL;
      end
    end
    bus_if.rwFromCache1 = IDEL;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus_if.errFlag !== 1'b1) begin
      n_err++; $display("FAIL err_sticky: got %b want 1", bus_if.errFlag);
    end
    do_reset();
    n_cmp++;
    if (bus_if.errFlag !== 1'b0) begin
      n_err++; $display("FAIL err_reset: got %b want 0", bus_if.errFlag);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mdl_last = 1'b1;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 16'h0;
    reset = 1'b0;
    drive0(IDEL, 16'h0, 16'h0);
    drive1(IDEL, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    test_reset();
    test_write_read();
    test_no_duplicate();
    test_round_robin();
    test_reset_abort();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
